// File: rtl/cancid_stream_ctx.sv
// ---------------------------------------------------------------------------
// cancid_stream_ctx
//   Per-regex stream-context engine. Wraps an external DFA through a
//   registered port pair, saves/restores the DFA state per stream ID across
//   packets, keeps a sticky per-packet match flag, and counts matched packets
//   (total and per stream, both saturating). A clear sweep zeroes the
//   per-stream count table one entry per cycle.
//
// Handshake: there is no backpressure anywhere. Every *_vld signal is a
//   single-cycle strobe qualifying its data on the same cycle; the consumer
//   must take it when it is high.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_state, new_stream_id start of packet; restore context (or force 0)
//   stream_id                 stream of the current packet
//   enable, eop               end of packet; save + count only when enable=1
//   char_in, char_in_vld      payload byte to the DFA
//   clear_counts              start (or restart) the count-clear sweep
//   dfa_char, dfa_char_vld    registered payload to the DFA
//   dfa_state, dfa_state_vld  restored state to the DFA (1-cycle pulse)
//   dfa_state_in, dfa_accept_in  DFA current state / accept
//   fired                     sticky match flag for the current packet
//   count_total               saturating count of matched packets
//   rd_sid, rd_count          per-stream count read, 1-cycle latency
//   busy                      clear sweep in progress (also the FSM state)
// ---------------------------------------------------------------------------
module cancid_stream_ctx #(
  parameter int STATE_W = 11,
  parameter int SID_W   = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               clear_counts,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state,
  output logic               dfa_state_vld,
  input  logic [STATE_W-1:0] dfa_state_in,
  input  logic               dfa_accept_in,
  output logic               fired,
  output logic [COUNT_W-1:0] count_total,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [COUNT_W-1:0] rd_count,
  output logic               busy
);

  localparam int NUM_STREAMS = 2**SID_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fsm_t;

  fsm_t               r_fsm;
  fsm_t               w_fsm_nxt;
  logic [SID_W-1:0]   r_idx;
  logic [SID_W-1:0]   w_idx_nxt;
  logic               w_sweep_start;
  logic               w_busy;

  logic [7:0]         r_dfa_char;
  logic               r_dfa_char_vld;
  logic               r_accept;
  logic [STATE_W-1:0] r_state;

  logic [STATE_W-1:0] r_state_mem [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] r_valid;
  logic [COUNT_W-1:0] r_cnt_mem [NUM_STREAMS];

  logic [STATE_W-1:0] r_dfa_state;
  logic               r_dfa_state_vld;
  logic               r_fired;
  logic [COUNT_W-1:0] r_count_total;
  logic [COUNT_W-1:0] r_rd_count;

  logic               w_save;
  logic               w_count;
  logic [STATE_W-1:0] w_restore;
  logic [COUNT_W-1:0] w_cnt_cur;

  assign w_save    = eop & enable;
  // A match is counted from the flag as it stands on the eop cycle.
  assign w_count   = w_save & r_fired & ~w_busy;
  assign w_cnt_cur = r_cnt_mem[stream_id];

  // Restore source: a same-cycle save of this stream forwards the value
  // being written so the DFA never sees the stale entry.
  always_comb begin
    w_restore = '0;
    if (new_stream_id) begin
      w_restore = '0;
    end else if (w_save) begin
      w_restore = r_state;
    end else if (r_valid[stream_id]) begin
      w_restore = r_state_mem[stream_id];
    end
  end

  // ---------------- clear-sweep FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_CLEAR;
      r_idx <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_idx_nxt     = r_idx;
    w_sweep_start = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (clear_counts) begin
          w_fsm_nxt     = ST_CLEAR;
          w_idx_nxt     = '0;
          w_sweep_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clear_counts) begin
          // Restart from entry 0; stay in CLEAR.
          w_idx_nxt     = '0;
          w_sweep_start = 1'b1;
        end else if (r_idx == {SID_W{1'b1}}) begin
          w_fsm_nxt = ST_IDLE;
          w_idx_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
        w_idx_nxt = '0;
      end
    endcase
  end

  assign w_busy = (r_fsm == ST_CLEAR);

  // ---------------- DFA port register stages ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dfa_char     <= '0;
      r_dfa_char_vld <= 1'b0;
      r_accept       <= 1'b0;
      r_state        <= '0;
    end else begin
      r_dfa_char     <= char_in;
      r_dfa_char_vld <= char_in_vld;
      r_accept       <= dfa_accept_in;
      r_state        <= dfa_state_in;
    end
  end

  // ---------------- context save / restore ----------------
  always_ff @(posedge clk) begin
    if (w_save) begin
      r_state_mem[stream_id] <= r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid         <= '0;
      r_dfa_state     <= '0;
      r_dfa_state_vld <= 1'b0;
    end else begin
      if (w_save) begin
        r_valid[stream_id] <= 1'b1;
      end
      r_dfa_state_vld <= load_state;
      if (load_state) begin
        r_dfa_state <= w_restore;
      end
    end
  end

  // ---------------- sticky match flag ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fired <= 1'b0;
    end else if (r_accept) begin
      r_fired <= 1'b1;
    end else if (load_state || (eop && !enable)) begin
      r_fired <= 1'b0;
    end
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_total <= '0;
    end else if (w_sweep_start) begin
      r_count_total <= '0;
    end else if (w_count && (r_count_total != {COUNT_W{1'b1}})) begin
      r_count_total <= r_count_total + 1'b1;
    end
  end

  // Count table needs no reset: every reset starts a sweep, and reads are
  // forced to 0 until the sweep has finished.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_cnt_mem[r_idx] <= '0;
    end else if (w_count && (w_cnt_cur != {COUNT_W{1'b1}})) begin
      r_cnt_mem[stream_id] <= w_cnt_cur + 1'b1;
    end
  end

  // Read port sees the pre-write value of a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
    end else if (w_busy) begin
      r_rd_count <= '0;
    end else begin
      r_rd_count <= r_cnt_mem[rd_sid];
    end
  end

  assign dfa_char      = r_dfa_char;
  assign dfa_char_vld  = r_dfa_char_vld;
  assign dfa_state     = r_dfa_state;
  assign dfa_state_vld = r_dfa_state_vld;
  assign fired         = r_fired;
  assign count_total   = r_count_total;
  assign rd_count      = r_rd_count;
  assign busy          = w_busy;

endmodule
